// File: rtl/grid_click_detector.sv
// Hover and click detector for an N_COLS x N_ROWS grid of card cells.
// Two-stage input pipeline feeds a press/release FSM that emits held valid/ready clicks.
module grid_click_detector #(
   parameter int X_POS  = 312,
   parameter int Y_POS  = 184,
   parameter int CELL_W = 96,
   parameter int CELL_H = 96,
   parameter int GAP    = 8,
   parameter int N_COLS = 4,
   parameter int N_ROWS = 4,
   parameter int IDX_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             mouse_left,
   input  logic [11:0]      mouse_xpos,
   input  logic [11:0]      mouse_ypos,
   input  logic             click_ready,
   output logic             hover_valid,
   output logic [IDX_W-1:0] hover_idx,
   output logic             click_valid,
   output logic [IDX_W-1:0] click_idx
);

   localparam int STEP_X = CELL_W + GAP;
   localparam int STEP_Y = CELL_H + GAP;

   typedef enum logic [1:0] {IDLE, ARMED, CANCEL, PENDING} state_t;

   logic [11:0]      x1_q, x1_d, y1_q, y1_d;
   logic             btn1_q, btn1_d;
   logic             hit2_q, hit2_d, btn2_q, btn2_d, prev2_q, prev2_d;
   logic [IDX_W-1:0] idx2_q, idx2_d;
   logic [IDX_W-1:0] armed_idx_q, armed_idx_d, click_idx_q, click_idx_d;
   state_t           state_q, state_d;

   logic [15:0]      xw, yw;
   logic             col_hit, row_hit, press, release_e;
   int               col_sel, row_sel;

   // Bounds are formed at 16 bits so X_POS + offsets can never wrap.
   always_comb begin
      xw      = {4'd0, x1_q};
      yw      = {4'd0, y1_q};
      col_hit = 1'b0;
      row_hit = 1'b0;
      col_sel = 0;
      row_sel = 0;
      for (int c = 0; c < N_COLS; c++) begin
         if (xw > 16'(X_POS + c*STEP_X) && xw < 16'(X_POS + c*STEP_X + CELL_W)) begin
            col_hit = 1'b1;
            col_sel = c;
         end
      end
      for (int r = 0; r < N_ROWS; r++) begin
         if (yw > 16'(Y_POS + r*STEP_Y) && yw < 16'(Y_POS + r*STEP_Y + CELL_H)) begin
            row_hit = 1'b1;
            row_sel = r;
         end
      end
   end

   assign press     = btn2_q & ~prev2_q;
   assign release_e = ~btn2_q & prev2_q;

   always_comb begin
      x1_d        = mouse_xpos;
      y1_d        = mouse_ypos;
      btn1_d      = mouse_left;
      hit2_d      = col_hit & row_hit;
      idx2_d      = (col_hit & row_hit) ? IDX_W'(row_sel*N_COLS + col_sel) : '0;
      btn2_d      = btn1_q;
      prev2_d     = btn2_q;
      state_d     = state_q;
      armed_idx_d = armed_idx_q;
      click_idx_d = click_idx_q;
      case (state_q)
         IDLE: begin
            if (enable && press) begin
               if (hit2_q) begin
                  state_d     = ARMED;
                  armed_idx_d = idx2_q;
               end else begin
                  state_d = CANCEL;
               end
            end
         end
         ARMED: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (release_e) begin
               if (hit2_q && idx2_q == armed_idx_q) begin
                  state_d     = PENDING;
                  click_idx_d = armed_idx_q;
               end else begin
                  state_d = IDLE;
               end
            end else if (!hit2_q || idx2_q != armed_idx_q) begin
               state_d = CANCEL;
            end
         end
         CANCEL: begin
            if (!enable || release_e) state_d = IDLE;
         end
         PENDING: begin
            // Committed click survives enable=0; only acceptance clears it.
            if (click_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x1_q        <= '0;
         y1_q        <= '0;
         btn1_q      <= 1'b0;
         hit2_q      <= 1'b0;
         idx2_q      <= '0;
         btn2_q      <= 1'b0;
         prev2_q     <= 1'b0;
         armed_idx_q <= '0;
         click_idx_q <= '0;
         state_q     <= IDLE;
      end else begin
         x1_q        <= x1_d;
         y1_q        <= y1_d;
         btn1_q      <= btn1_d;
         hit2_q      <= hit2_d;
         idx2_q      <= idx2_d;
         btn2_q      <= btn2_d;
         prev2_q     <= prev2_d;
         armed_idx_q <= armed_idx_d;
         click_idx_q <= click_idx_d;
         state_q     <= state_d;
      end
   end

   assign hover_valid = enable & hit2_q;
   assign hover_idx   = enable ? idx2_q : '0;
   assign click_valid = (state_q == PENDING);
   assign click_idx   = click_idx_q;

endmodule

// File: doc/grid_click_detector.md
Name: grid_click_detector

Overview:
- Parametrised successor to the single-region click checker. Covers an N_COLS x N_ROWS grid of equal card cells separated by gaps.
- Reports the currently hovered cell every cycle.
- Emits a committed click (press and release inside the same cell) as a held valid/ready event carrying the cell index.
- Sits between the mouse controller and the game FSM. The game FSM consumes clicks at its own pace.

Parameters:
X_POS, 312, x of the grid's left edge (pixels)
Y_POS, 184, y of the grid's top edge (pixels)
CELL_W, 96, cell width (pixels)
CELL_H, 96, cell height (pixels)
GAP, 8, spacing between adjacent cells, both axes (pixels)
N_COLS, 4, number of columns
N_ROWS, 4, number of rows
IDX_W, 4, index width; must be >= clog2(N_COLS*N_ROWS)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enable  in  1  detection enable
mouse_left  in  1  left button level, 1 = pressed
mouse_xpos  in  12  cursor x
mouse_ypos  in  12  cursor y
click_ready  in  1  consumer accepts the pending click
hover_valid  out  1  cursor is inside some cell
hover_idx  out  IDX_W  hovered cell, row*N_COLS+col; 0 when hover_valid=0
click_valid  out  1  click event pending
click_idx  out  IDX_W  clicked cell index, stable while click_valid=1

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. All outputs are 0, FSM goes to IDLE, pipeline registers are 0, and the previous-button register is 0.
- Hit rule, per axis:
  - Cell col c has left edge L = X_POS + c*(CELL_W+GAP).
  - x is inside when L < x < L+CELL_W. Both bounds are strict, so edge pixels and gap pixels are outside.
  - The y axis uses the same rule with Y_POS, r and CELL_H.
  - All comparisons use widths of at least 14 bits so that bound sums never wrap.
  - Inside requires both axes inside. At most one cell can hit.
- Pipeline:
  - Stage 1 registers xpos, ypos and mouse_left.
  - Stage 2 registers the hit flag, the hit index, the button level and the previous button level.
  - hover_valid/hover_idx are driven from stage 2: latency 2 edges. Both are forced to 0 when enable=0 (combinationally gated).
- Edges: press = stage-2 button rises (prev 0, now 1). Release = stage-2 button falls.
- FSM states: IDLE, ARMED, CANCEL, PENDING.
  - IDLE: press with hit -> ARMED, latch armed_idx = hit index. Press without hit -> CANCEL.
  - ARMED:
    - Release with hit and hit index == armed_idx -> PENDING, click_idx = armed_idx.
    - Release otherwise -> IDLE, no event.
    - Still held and (no hit or hit index != armed_idx) -> CANCEL.
  - CANCEL: release -> IDLE. Cancel is sticky: returning to the armed cell does not re-arm.
  - PENDING: click_valid=1. click_ready=1 -> IDLE, and click_valid drops on the next edge. Presses and releases while in PENDING are ignored and not queued.
- Same-cycle cases: position and button are sampled together, so the cursor position in the release sample alone decides. click_ready is evaluated only in PENDING.
- enable=0: ARMED/CANCEL -> IDLE next edge. No press is recognised in IDLE. PENDING is held until accepted; a committed event is never dropped.
- Click latency: click_valid rises on the 3rd edge after the first cycle mouse_left is presented low.
- Reset mid-operation: any state -> IDLE and click_valid=0 on the edge where rst=1.

Test Plan:
1. Cursor at (360,230), mouse_left 1 for 4 cycles then 0, click_ready=1 -> click_valid pulses exactly 1 cycle with click_idx=0, 3 edges after the release input.
2. Press and release at (460,330) with click_ready=0 for 5 cycles, then 1 -> click_valid held 6 cycles, click_idx=5 constant, low the edge after acceptance.
3. Boundaries: (312,230), (408,230) and (412,230, in the gap) -> hover_valid=0. (313,185) -> hover_valid=1, hover_idx=0. Press/release at (412,230) -> no click.
4. Press at (360,230), move to (460,230) (cell 1), move back to (360,230), release -> no click; FSM returns to IDLE. A following clean click at (360,230) yields click_idx=0.
5. Press in cell 0, drop enable for 1 cycle while held, release -> no click. Rst asserted during PENDING -> click_valid=0 next edge.
6. Step cursor from (0,0) to (680,550) -> hover_valid=1, hover_idx=15 exactly 2 edges later. With enable=0 -> hover_valid=0, hover_idx=0.
